serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes diff = in1 - in2 - bin over WIDTH bits, LSB first, one bit per clock.
- Uses a single full-subtractor cell (borrow chain), the subtract-direction counterpart of the full_adder cell.
- Valid/ready handshake on input and output, so it sits between any two streaming stages in the arithmetic datapath.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = in1 - in2 - bin over WIDTH bits, LSB first, one bit per clock,
// with valid/ready on both sides. Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // One full-subtractor cell; returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [1:0]       fs;

    assign fs = full_sub(a_q[0], b_q[0], borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in1;
                    b_d      = in2;
                    borrow_d = bin;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = fs[1];
                res_d    = {fs[0], res_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                // Final bit goes straight into the output register alongside the last shift.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs[0], res_q[WIDTH-1:1]};
                    bout_d  = fs[1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Datapath shift registers need no reset: every accept reloads them.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        borrow_q <= borrow_d;
        res_q    <= res_d;
        cnt_q    <= cnt_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // In the last RUN cycle a_q[0]/b_q[0] hold the operand MSBs and fs[0] is the result MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && cnt_q == LAST_BIT)
            ovf_d = (a_q[0] != b_q[0]) && (fs[0] != a_q[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors plus a random soak.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation, waits for the result and returns it with the accept-to-valid latency.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic bi,
                         output logic [7:0] d, output logic bo, output int lat, output bit ok);
        int w;
        ok = 1'b1;
        w  = 0;
        while (!in_ready && w < 40) begin
            step();
            w++;
        end
        if (!in_ready) ok = 1'b0;
        in1 = x;
        in2 = y;
        bin = bi;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        d  = diff;
        bo = bout;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in1 = 8'hAA;
        in2 = 8'h11;
        bin = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff: got %h expected 00", diff); end
        checks++;
        if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        step();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_hold: in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        bit run_busy;
        in1 = 8'h5A;
        in2 = 8'h3C;
        bin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        run_busy = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) run_busy = 1'b1;
            step();
            lat++;
        end
        checks++;
        if (run_busy) begin failures++; $display("FAIL basic_in_ready_run: got 1 during RUN expected 0"); end
        checks++;
        if (lat != 8) begin failures++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++;
        if (diff !== 8'h1E) begin failures++; $display("FAIL basic_diff: got %h expected 1e", diff); end
        checks++;
        if (bout !== 1'b0) begin failures++; $display("FAIL basic_bout: got %b expected 0", bout); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_single_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_idle: got %b expected 1", in_ready); end
        // out_ready left high while idle must not disturb anything.
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_ready_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        logic bo;
        int lat;
        bit ok;
        do_op(8'h00, 8'h01, 1'b0, d, bo, lat, ok);
        release_result();
        checks++;
        if (!ok || d !== 8'hFF || bo !== 1'b1) begin
            failures++; $display("FAIL underflow_00_01: got %h/%b ok=%0d expected ff/1", d, bo, ok);
        end
        do_op(8'h10, 8'h0F, 1'b1, d, bo, lat, ok);
        release_result();
        checks++;
        if (!ok || d !== 8'h00 || bo !== 1'b0) begin
            failures++; $display("FAIL borrow_in_10_0f: got %h/%b ok=%0d expected 00/0", d, bo, ok);
        end
        do_op(8'hC3, 8'hC3, 1'b0, d, bo, lat, ok);
        release_result();
        checks++;
        if (!ok || d !== 8'h00 || bo !== 1'b0) begin
            failures++; $display("FAIL equal_operands: got %h/%b ok=%0d expected 00/0", d, bo, ok);
        end
        do_op(8'h00, 8'h00, 1'b1, d, bo, lat, ok);
        release_result();
        checks++;
        if (!ok || d !== 8'hFF || bo !== 1'b1) begin
            failures++; $display("FAIL zero_minus_bin: got %h/%b ok=%0d expected ff/1", d, bo, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic bo;
        int lat;
        bit ok;
        bit unstable;
        do_op(8'h00, 8'h01, 1'b0, d, bo, lat, ok);
        checks++;
        if (!ok || d !== 8'hFF || bo !== 1'b1) begin
            failures++; $display("FAIL bp_result: got %h/%b ok=%0d expected ff/1", d, bo, ok);
        end
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in1 = 8'h77;
            in2 = 8'h11;
            step();
            if (out_valid !== 1'b1 || diff !== 8'hFF || bout !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (unstable) begin
            failures++; $display("FAIL bp_stable: got %h/%b valid=%b expected ff/1 valid=1", diff, bout, out_valid);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        logic bo;
        int lat;
        bit ok;
        in1 = 8'h9C;
        in2 = 8'h21;
        bin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reset: in_ready=%b out_valid=%b diff=%h bout=%b expected 1/0/00/0",
                     in_ready, out_valid, diff, bout);
        end
        do_op(8'h05, 8'h03, 1'b0, d, bo, lat, ok);
        checks++;
        if (!ok || lat != 8 || d !== 8'h02 || bo !== 1'b0) begin
            failures++; $display("FAIL after_reset_op: got %h/%b lat=%0d expected 02/0 lat=8", d, bo, lat);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_05_03: got %b expected 0", ovf); end
`endif
        release_result();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [7:0] d;
        logic bo;
        int lat;
        bit ok;
        do_op(8'h80, 8'h01, 1'b0, d, bo, lat, ok);
        checks++;
        if (!ok || d !== 8'h7F || bo !== 1'b0 || ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_80_01: got %h/%b/%b expected 7f/0/1", d, bo, ovf);
        end
        release_result();
        do_op(8'h7F, 8'hFF, 1'b0, d, bo, lat, ok);
        checks++;
        if (!ok || d !== 8'h80 || bo !== 1'b1 || ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_7f_ff: got %h/%b/%b expected 80/1/1", d, bo, ovf);
        end
        release_result();
    endtask
`endif

    task automatic test_soak();
        logic [7:0] x, y, d;
        logic bi, bo;
        logic [8:0] exp9;
        int lat;
        int stall;
        bit ok;
        bit held;
        for (int n = 0; n < 1000; n++) begin
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            exp9 = {1'b0, x} - {1'b0, y} - {8'b0, bi};
            do_op(x, y, bi, d, bo, lat, ok);
            checks++;
            if (!ok || lat != 8 || d !== exp9[7:0] || bo !== exp9[8]) begin
                failures++;
                $display("FAIL soak_%0d: %h-%h-%b got %h/%b lat=%0d expected %h/%b lat=8",
                         n, x, y, bi, d, bo, lat, exp9[7:0], exp9[8]);
            end
            stall = $urandom_range(0, 3);
            held = 1'b1;
            for (int s = 0; s < stall; s++) begin
                step();
                if (out_valid !== 1'b1 || diff !== exp9[7:0] || bout !== exp9[8]) held = 1'b0;
            end
            release_result();
            checks++;
            if (!held || out_valid !== 1'b0) begin
                failures++; $display("FAIL soak_hold_%0d: held=%0d out_valid=%b expected 1/0", n, held, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
